// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: debounced RUN/STEP/HALT buttons produce one CPU clock enable,
// with N-cycle stepping, a fetch-PC breakpoint and a count of enabled cycles.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_W          = 8,
  parameter int PC_W            = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_halt,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc_fe,
  output logic              cpu_en,
  output logic [1:0]        run_state,
  output logic              bp_hit,
  output logic [31:0]       cycle_cnt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t            state, state_next;
  logic [STEP_W-1:0] step_left, step_left_next, step_load;
  logic              bp_skip, bp_skip_next, bp_match;
  logic              run_p, step_p, halt_p;

  // Bit order for all button vectors: [0] RUN, [1] STEP, [2] HALT
  logic [2:0]       btn_raw, sync1, sync2, deb, deb_d, pulse;
  logic [CNT_W-1:0] deb_cnt [3];

  assign btn_raw = {btn_halt, btn_step, btn_run};

  // A button's debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb_cnt[i] <= '0;
          deb[i]     <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pulse  = deb & ~deb_d;
  assign run_p  = pulse[0];
  assign step_p = pulse[1];
  assign halt_p = pulse[2];

  assign step_load = (step_count == '0) ? STEP_W'(1) : step_count;
  assign bp_match  = bp_en && (pc_fe == bp_addr) && !bp_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HALT;
      step_left <= '0;
      bp_skip   <= 1'b0;
    end else begin
      state     <= state_next;
      step_left <= step_left_next;
      bp_skip   <= bp_skip_next;
    end
  end

  always_comb begin
    state_next     = state;
    step_left_next = step_left;
    bp_skip_next   = bp_skip;
    if (bp_skip && (!bp_en || (pc_fe != bp_addr))) bp_skip_next = 1'b0;
    if (halt_p) begin
      state_next     = S_HALT;
      step_left_next = '0;
      bp_skip_next   = 1'b0;
    end else begin
      case (state)
        S_HALT: begin
          if (step_p) begin
            state_next     = S_STEP;
            step_left_next = step_load;
          end else if (run_p) begin
            state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (bp_match) state_next = S_BREAK;
        end
        S_STEP: begin
          if (bp_match) begin
            state_next     = S_BREAK;
            step_left_next = '0;
          end else if (cpu_en) begin
            step_left_next = step_left - STEP_W'(1);
            if (step_left == STEP_W'(1)) state_next = S_HALT;
          end
        end
        S_BREAK: begin
          // Resuming arms bp_skip so the parked instruction can leave fetch
          if (step_p) begin
            state_next     = S_STEP;
            step_left_next = step_load;
            bp_skip_next   = 1'b1;
          end else if (run_p) begin
            state_next   = S_RUN;
            bp_skip_next = 1'b1;
          end
        end
        default: state_next = S_HALT;
      endcase
    end
  end

  always_comb begin
    cpu_en    = ((state == S_RUN) || (state == S_STEP)) && !bp_match;
    bp_hit    = (state == S_BREAK);
    run_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_cnt <= '0;
    else if (cpu_en) cycle_cnt <= cycle_cnt + 32'd1;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomised, scoreboard-checked bench for cpu_run_ctrl against a behavioural model of
// button debouncing and run/step/break sequencing.
module tb_cpu_run_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n, btn_run, btn_step, btn_halt, bp_en;
  logic [7:0]  step_count;
  logic [31:0] bp_addr, pc_fe;
  logic        cpu_en, bp_hit;
  logic [1:0]  run_state;
  logic [31:0] cycle_cnt;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_W(8), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
    .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc_fe(pc_fe),
    .cpu_en(cpu_en), .run_state(run_state), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  st;
    logic        hit;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: 0 HALT, 1 RUN, 2 STEP, 3 BREAK
  int          m_state, m_left;
  bit          m_skip, auto_pc;
  logic [31:0] m_cnt;
  logic [2:0]  m_deb, m_deb_prev;
  logic [2:0]  raw_hist[$];

  function automatic void model_reset();
    m_state = 0; m_left = 0; m_skip = 0; m_cnt = 0;
    m_deb = 3'b000; m_deb_prev = 3'b000;
    raw_hist.delete();
    for (int i = 0; i < D + 2; i++) raw_hist.push_back(3'b000);
  endfunction

  // Pushes this cycle's expected outputs, then advances the model across one clock edge
  task automatic apply_stimulus();
    exp_t       e;
    bit         match, en, all_diff;
    logic [2:0] p, raw, nd;
    int         load;
    match = bp_en && (pc_fe == bp_addr) && !m_skip;
    en    = ((m_state == 1) || (m_state == 2)) && !match;
    e.en = en; e.st = 2'(m_state); e.hit = (m_state == 3); e.cnt = m_cnt;
    sb_q.push_back(e);
    raw = {btn_halt, btn_step, btn_run};
    @(posedge clk);
    p    = m_deb & ~m_deb_prev;
    load = (step_count == 8'd0) ? 1 : int'(step_count);
    if (en) m_cnt = m_cnt + 32'd1;
    if (m_skip && (!bp_en || pc_fe != bp_addr)) m_skip = 0;
    if (p[2]) begin
      m_state = 0; m_left = 0; m_skip = 0;
    end else begin
      case (m_state)
        0: if (p[1]) begin m_state = 2; m_left = load; end else if (p[0]) m_state = 1;
        1: if (match) m_state = 3;
        2: if (match) begin m_state = 3; m_left = 0; end
           else begin m_left = m_left - 1; if (m_left == 0) m_state = 0; end
        default: if (p[1]) begin m_state = 2; m_left = load; m_skip = 1; end
                 else if (p[0]) begin m_state = 1; m_skip = 1; end
      endcase
    end
    raw_hist.push_front(raw);
    void'(raw_hist.pop_back());
    nd = m_deb;
    for (int b = 0; b < 3; b++) begin
      all_diff = 1;
      for (int j = 2; j < D + 2; j++) if (raw_hist[j][b] == m_deb[b]) all_diff = 0;
      if (all_diff) nd[b] = ~m_deb[b];
    end
    m_deb_prev = m_deb;
    m_deb = nd;
    #1;
    if (auto_pc && en) pc_fe = (pc_fe >= 32'h20) ? 32'h0 : pc_fe + 32'd4;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (cpu_en !== e.en || run_state !== e.st || bp_hit !== e.hit || cycle_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL scoreboard t=%0t: got en=%b st=%b hit=%b cnt=%0d, expected en=%b st=%b hit=%b cnt=%0d",
                 $time, cpu_en, run_state, bp_hit, cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cycles(int n);
    repeat (n) apply_stimulus();
  endtask

  task automatic press(logic [2:0] mask, int hold, int after);
    {btn_halt, btn_step, btn_run} = mask;
    run_cycles(hold);
    {btn_halt, btn_step, btn_run} = 3'b000;
    run_cycles(after);
  endtask

  task automatic wait_state(int target, int limit, string name);
    int k = 0;
    while (m_state != target && k < limit) begin
      apply_stimulus();
      k++;
    end
    if (m_state != target) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: timeout after %0d cycles, model state %0d, required %0d", name, limit, m_state, target);
    end
  endtask

  task automatic step_raw(logic v, int n);
    btn_step = v;
    run_cycles(n);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] c0;
    logic [2:0]  rb;
    rst_n = 1'b0; btn_run = 0; btn_step = 0; btn_halt = 0;
    step_count = 8'd0; bp_en = 0; bp_addr = 32'h0; pc_fe = 32'h0; auto_pc = 0;
    model_reset();
    #3;
    check_output("reset_cpu_en", 32'(cpu_en), 32'd0);
    check_output("reset_state", 32'(run_state), 32'd0);
    check_output("reset_bp_hit", 32'(bp_hit), 32'd0);
    check_output("reset_cycle_cnt", cycle_cnt, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_cycles(20);
    check_output("idle_state", 32'(run_state), 32'd0);
    check_output("idle_cycle_cnt", cycle_cnt, 32'd0);

    step_count = 8'd3;
    press(3'b010, 10, 20);
    check_output("step3_cnt", cycle_cnt, 32'd3);
    check_output("step3_state", 32'(run_state), 32'd0);
    step_count = 8'd0;
    press(3'b010, 10, 20);
    check_output("step0_cnt", cycle_cnt, 32'd4);

    bp_en = 1; bp_addr = 32'h18; pc_fe = 32'h0; auto_pc = 1;
    press(3'b001, 8, 0);
    wait_state(3, 60, "bp_first_hit");
    check_output("bp_state", 32'(run_state), 32'd3);
    check_output("bp_hit", 32'(bp_hit), 32'd1);
    check_output("bp_cpu_en", 32'(cpu_en), 32'd0);
    check_output("bp_cnt", cycle_cnt, 32'd10);
    press(3'b001, 8, 0);
    check_output("bp_resume_state", 32'(run_state), 32'd1);
    wait_state(3, 60, "bp_rehit");
    check_output("bp_rehit_cnt", cycle_cnt, 32'd19);
    press(3'b100, 8, 4);
    check_output("bp_halt_state", 32'(run_state), 32'd0);
    auto_pc = 0; bp_en = 0;

    step_count = 8'd1;
    step_raw(1, 1); step_raw(0, 1); step_raw(1, 1); step_raw(0, 2);
    step_raw(1, 3); step_raw(0, 12);
    check_output("glitch_state", 32'(run_state), 32'd0);
    check_output("glitch_cnt", cycle_cnt, 32'd19);
    press(3'b010, 8, 10);
    check_output("held_step_cnt", cycle_cnt, 32'd20);

    press(3'b001, 8, 2);
    check_output("run_state", 32'(run_state), 32'd1);
    press(3'b111, 8, 4);
    check_output("all_btn_state", 32'(run_state), 32'd0);
    c0 = m_cnt;
    step_count = 8'd5;
    press(3'b011, 8, 12);
    check_output("run_step_cnt", cycle_cnt, c0 + 32'd5);
    check_output("run_step_state", 32'(run_state), 32'd0);

    auto_pc = 1; pc_fe = 32'h0;
    rb = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) rb ^= (3'b001 << $urandom_range(0, 2));
      {btn_halt, btn_step, btn_run} = rb;
      if ($urandom_range(0, 19) == 0) step_count = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) bp_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) bp_addr = 32'($urandom_range(0, 8)) * 32'd4;
      if ($urandom_range(0, 29) == 0) pc_fe = 32'($urandom_range(0, 8)) * 32'd4;
      apply_stimulus();
    end
    {btn_halt, btn_step, btn_run} = 3'b000;
    auto_pc = 0; bp_en = 0;
    run_cycles(20);
    press(3'b100, 8, 4);

    step_count = 8'd200;
    press(3'b010, 8, 5);
    check_output("midstep_state", 32'(run_state), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_cpu_en", 32'(cpu_en), 32'd0);
    check_output("async_state", 32'(run_state), 32'd0);
    check_output("async_bp_hit", 32'(bp_hit), 32'd0);
    check_output("async_cnt", cycle_cnt, 32'd0);
    sb_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycles(10);
    check_output("post_reset_state", 32'(run_state), 32'd0);
    check_output("post_reset_cnt", cycle_cnt, 32'd0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
